// File: rtl/dual_issue_pair_splitter_pkg.sv
// Shared definitions for the dual-issue pair splitter: RV32 opcode
// constants, field widths and the splitter state encoding.
package dual_issue_pair_splitter_pkg;

    localparam int unsigned OPC_W = 7;
    localparam int unsigned REG_W = 5;
    localparam int unsigned ENC_W = 32;

    localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;

    // PAIR: both slots may issue together; SECOND: the buffered slot 2 issues on lane 1
    typedef enum logic {
        PAIR   = 1'b0,
        SECOND = 1'b1
    } state_e;

endpackage

// File: rtl/dual_issue_pair_splitter_fields.sv
// instr_reg_fields: combinational register-field decode of one instruction.
// Ports:
//   instr_i       instruction encoding
//   rd_o/rs1_o/rs2_o  register specifier fields
//   uses_rs1_o    instruction reads rs1
//   uses_rs2_o    instruction reads rs2 (R, S, B types)
//   writes_rd_o   instruction writes rd
//   is_mem_o      load or store
module instr_reg_fields
    import dual_issue_pair_splitter_pkg::*;
(
    input  logic [ENC_W-1:0] instr_i,
    output logic [REG_W-1:0] rd_o,
    output logic [REG_W-1:0] rs1_o,
    output logic [REG_W-1:0] rs2_o,
    output logic             uses_rs1_o,
    output logic             uses_rs2_o,
    output logic             writes_rd_o,
    output logic             is_mem_o
);

    logic [OPC_W-1:0] opcode;
    // funct3/funct7 do not affect hazard decisions
    logic             unused_funct;

    assign opcode       = instr_i[6:0];
    assign unused_funct = ^{instr_i[31:25], instr_i[14:12]};

    assign rd_o  = instr_i[11:7];
    assign rs1_o = instr_i[19:15];
    assign rs2_o = instr_i[24:20];

    // Per-opcode register usage
    always_comb begin
        uses_rs1_o  = 1'b1;
        uses_rs2_o  = 1'b0;
        writes_rd_o = 1'b0;
        is_mem_o    = 1'b0;
        case (opcode)
            OP_R: begin
                uses_rs2_o  = 1'b1;
                writes_rd_o = 1'b1;
            end
            OP_IMM:    writes_rd_o = 1'b1;
            OP_LOAD: begin
                writes_rd_o = 1'b1;
                is_mem_o    = 1'b1;
            end
            OP_STORE: begin
                uses_rs2_o = 1'b1;
                is_mem_o   = 1'b1;
            end
            OP_BRANCH: uses_rs2_o = 1'b1;
            OP_JALR:   writes_rd_o = 1'b1;
            OP_JAL, OP_LUI, OP_AUIPC: begin
                uses_rs1_o  = 1'b0;
                writes_rd_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dual_issue_pair_splitter.sv
// dual_issue_pair_splitter: decides what each execute lane receives from the
// fetched instruction pair. Dependent (RAW) or dual-memory pairs are split:
// slot 1 issues alone, slot 2 is buffered and issues on lane 1 next cycle.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   StallIn, FlushD       external stall (hold) and decode flush
//   ValidD*/InstrD*/PCD*  fetched pair (slot 1 older)
//   InstrL*/PCL*/ValidL*  lane 1 / lane 2 issue (flush = !Valid)
//   StallFD               hold PC and fetch/decode register
//   SplitBusy             buffered slot 2 is issuing
module dual_issue_pair_splitter
    import dual_issue_pair_splitter_pkg::*;
#(
    parameter int unsigned XLEN              = 32,
    parameter int unsigned SPLIT_ON_DUAL_MEM = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallIn,
    input  logic            FlushD,
    input  logic            ValidD1,
    input  logic            ValidD2,
    input  logic [XLEN-1:0] InstrD1,
    input  logic [XLEN-1:0] InstrD2,
    input  logic [XLEN-1:0] PCD1,
    input  logic [XLEN-1:0] PCD2,
    output logic [XLEN-1:0] InstrL1,
    output logic [XLEN-1:0] PCL1,
    output logic            ValidL1,
    output logic [XLEN-1:0] InstrL2,
    output logic [XLEN-1:0] PCL2,
    output logic            ValidL2,
    output logic            StallFD,
    output logic            SplitBusy
);

    localparam bit DUAL_MEM_SPLIT = (SPLIT_ON_DUAL_MEM != 0);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   buf_instr_q, buf_instr_d;
    logic [XLEN-1:0]   buf_pc_q, buf_pc_d;

    logic [REG_W-1:0]  rd1, rs1_1, rs2_1, rd2, rs1_2, rs2_2;
    logic              uses_rs1_1, uses_rs2_1, writes_rd1, is_mem1;
    logic              uses_rs1_2, uses_rs2_2, writes_rd2, is_mem2;
    logic              raw, mem, conflict;
    logic              unused_fields;

    instr_reg_fields u_fields_1 (
        .instr_i     (InstrD1[ENC_W-1:0]),
        .rd_o        (rd1),
        .rs1_o       (rs1_1),
        .rs2_o       (rs2_1),
        .uses_rs1_o  (uses_rs1_1),
        .uses_rs2_o  (uses_rs2_1),
        .writes_rd_o (writes_rd1),
        .is_mem_o    (is_mem1)
    );

    instr_reg_fields u_fields_2 (
        .instr_i     (InstrD2[ENC_W-1:0]),
        .rd_o        (rd2),
        .rs1_o       (rs1_2),
        .rs2_o       (rs2_2),
        .uses_rs1_o  (uses_rs1_2),
        .uses_rs2_o  (uses_rs2_2),
        .writes_rd_o (writes_rd2),
        .is_mem_o    (is_mem2)
    );

    // Slot 1 sources and slot 2 destination never create a hazard within a pair
    assign unused_fields = ^{rs1_1, rs2_1, uses_rs1_1, uses_rs2_1, rd2, writes_rd2};

    // Slot 2 reads what slot 1 writes (x0 never creates a dependence)
    assign raw = writes_rd1 && (rd1 != '0) &&
                 ((uses_rs1_2 && (rs1_2 == rd1)) || (uses_rs2_2 && (rs2_2 == rd1)));
    assign mem      = DUAL_MEM_SPLIT && is_mem1 && is_mem2;
    assign conflict = ValidD1 && ValidD2 && (raw || mem);

    // State and slot-2 buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PAIR;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    // Next state and lane selection
    always_comb begin
        state_d     = state_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        InstrL1     = InstrD1;
        PCL1        = PCD1;
        ValidL1     = ValidD1;
        InstrL2     = InstrD2;
        PCL2        = PCD2;
        ValidL2     = ValidD2;
        StallFD     = 1'b0;
        SplitBusy   = (state_q == SECOND);

        case (state_q)
            PAIR: begin
                if (conflict) begin
                    ValidL1 = 1'b1;
                    ValidL2 = 1'b0;
                    if (!StallIn) begin
                        buf_instr_d = InstrD2;
                        buf_pc_d    = PCD2;
                        state_d     = SECOND;
                    end
                end
            end
            SECOND: begin
                InstrL1 = buf_instr_q;
                PCL1    = buf_pc_q;
                ValidL1 = 1'b1;
                ValidL2 = 1'b0;
                // Decided from state alone so the decode compare never reaches fetch
                StallFD = 1'b1;
                if (!StallIn) begin
                    state_d = PAIR;
                end
            end
            default: state_d = PAIR;
        endcase

        if (StallIn) begin
            StallFD = 1'b1;
        end

        // Flush beats stall and conflict; any buffered instruction is dropped
        if (FlushD) begin
            ValidL1     = 1'b0;
            ValidL2     = 1'b0;
            StallFD     = 1'b0;
            state_d     = PAIR;
            buf_instr_d = buf_instr_q;
            buf_pc_d    = buf_pc_q;
        end

        if (rst) begin
            InstrL1   = '0;
            PCL1      = '0;
            ValidL1   = 1'b0;
            InstrL2   = '0;
            PCL2      = '0;
            ValidL2   = 1'b0;
            StallFD   = 1'b0;
            SplitBusy = 1'b0;
        end
    end

endmodule

// File: tb/tb_dual_issue_pair_splitter.sv
module tb_dual_issue_pair_splitter;

    logic        clk = 1'b0;
    logic        rst, StallIn, FlushD, ValidD1, ValidD2;
    logic [31:0] InstrD1, InstrD2, PCD1, PCD2;
    logic [31:0] InstrL1, PCL1, InstrL2, PCL2;
    logic        ValidL1, ValidL2, StallFD, SplitBusy;
    logic [31:0] n_InstrL1, n_PCL1, n_InstrL2, n_PCL2;
    logic        n_ValidL1, n_ValidL2, n_StallFD, n_SplitBusy;

    always #5 clk = ~clk;

    dual_issue_pair_splitter #(.XLEN(32), .SPLIT_ON_DUAL_MEM(1)) dut (
        .clk(clk), .rst(rst), .StallIn(StallIn), .FlushD(FlushD),
        .ValidD1(ValidD1), .ValidD2(ValidD2), .InstrD1(InstrD1), .InstrD2(InstrD2),
        .PCD1(PCD1), .PCD2(PCD2), .InstrL1(InstrL1), .PCL1(PCL1), .ValidL1(ValidL1),
        .InstrL2(InstrL2), .PCL2(PCL2), .ValidL2(ValidL2), .StallFD(StallFD),
        .SplitBusy(SplitBusy)
    );

    dual_issue_pair_splitter #(.XLEN(32), .SPLIT_ON_DUAL_MEM(0)) dut_nomem (
        .clk(clk), .rst(rst), .StallIn(StallIn), .FlushD(FlushD),
        .ValidD1(ValidD1), .ValidD2(ValidD2), .InstrD1(InstrD1), .InstrD2(InstrD2),
        .PCD1(PCD1), .PCD2(PCD2), .InstrL1(n_InstrL1), .PCL1(n_PCL1), .ValidL1(n_ValidL1),
        .InstrL2(n_InstrL2), .PCL2(n_PCL2), .ValidL2(n_ValidL2), .StallFD(n_StallFD),
        .SplitBusy(n_SplitBusy)
    );

    typedef struct {
        logic        rst, stall, flush, v1, v2;
        logic [31:0] i1, p1, i2, p2;
        logic        ev1, ev2, estf, ebusy;
        logic [31:0] ei1, ep1, ei2, ep2;
        logic        chk_nomem;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction

    function automatic vec_t mk(input logic r, input logic st, input logic fl, input logic v1, input logic v2,
                                input logic [31:0] i1, input logic [31:0] p1, input logic [31:0] i2, input logic [31:0] p2,
                                input logic ev1, input logic ev2, input logic estf, input logic ebusy,
                                input logic [31:0] ei1, input logic [31:0] ep1, input logic [31:0] ei2, input logic [31:0] ep2);
        vec_t v;
        v.rst = r; v.stall = st; v.flush = fl; v.v1 = v1; v.v2 = v2;
        v.i1 = i1; v.p1 = p1; v.i2 = i2; v.p2 = p2;
        v.ev1 = ev1; v.ev2 = ev2; v.estf = estf; v.ebusy = ebusy;
        v.ei1 = ei1; v.ep1 = ep1; v.ei2 = ei2; v.ep2 = ep2;
        v.chk_nomem = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
        end
    endtask

    initial begin
        logic [31:0] a1, a2, n1, n2, b2, lw, sw, ad0, ad6, lu5, lu6, rs2dep, beq5, waw;
        vec_t v, e;

        a1     = enc_r(5'd5, 5'd1, 5'd2);             // add x5,x1,x2
        a2     = enc_r(5'd6, 5'd5, 5'd3);             // add x6,x5,x3
        n1     = enc_r(5'd10, 5'd11, 5'd12);
        n2     = enc_r(5'd13, 5'd14, 5'd15);
        b2     = enc_r(5'd6, 5'd7, 5'd8);
        lw     = enc_i(7'b0000011, 3'b010, 5'd5, 5'd1, 12'd0);
        sw     = enc_s(5'd2, 5'd6, 12'd4);
        ad0    = enc_i(7'b0010011, 3'b000, 5'd0, 5'd0, 12'd1);
        ad6    = enc_r(5'd6, 5'd0, 5'd0);
        lu5    = enc_lui(5'd5, 20'd1);
        lu6    = enc_lui(5'd6, 20'h00028);            // rs1 field bits read as x5
        rs2dep = enc_r(5'd6, 5'd3, 5'd5);             // add x6,x3,x5
        beq5   = {7'd0, 5'd2, 5'd1, 3'd0, 5'd5, 7'b1100011};
        waw    = enc_r(5'd5, 5'd3, 5'd4);

        //           rst st fl v1 v2  i1  p1       i2      p2        ev1 ev2 stf bsy ei1 ep1     ei2 ep2
        vecs.push_back(mk(1,0,0,1,1, a1, 32'h100, a2, 32'h104,   0,0,0,0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, a1, 32'h100, a2, 32'h104,   1,0,0,0, a1, 32'h100, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, n1, 32'h108, n2, 32'h10c,   1,0,1,1, a2, 32'h104, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, n1, 32'h108, n2, 32'h10c,   1,1,0,0, n1, 32'h108, n2, 32'h10c));
        vecs.push_back(mk(0,0,0,1,1, a1, 32'h200, b2, 32'h204,   1,1,0,0, a1, 32'h200, b2, 32'h204));
        v = mk(0,0,0,1,1, lw, 32'h300, sw, 32'h304,              1,0,0,0, lw, 32'h300, 0, 0);
        v.chk_nomem = 1'b1;
        vecs.push_back(v);
        vecs.push_back(mk(0,0,0,1,1, ad0, 32'h308, ad6, 32'h30c, 1,0,1,1, sw, 32'h304, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, ad0, 32'h308, ad6, 32'h30c, 1,1,0,0, ad0, 32'h308, ad6, 32'h30c));
        vecs.push_back(mk(0,0,0,1,1, lu5, 32'h310, lu6, 32'h314, 1,1,0,0, lu5, 32'h310, lu6, 32'h314));
        vecs.push_back(mk(0,0,0,1,1, a1, 32'h320, rs2dep, 32'h324, 1,0,0,0, a1, 32'h320, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, beq5, 32'h330, a2, 32'h334, 1,0,1,1, rs2dep, 32'h324, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, beq5, 32'h330, a2, 32'h334, 1,1,0,0, beq5, 32'h330, a2, 32'h334));
        vecs.push_back(mk(0,0,0,1,1, a1, 32'h340, waw, 32'h344,  1,1,0,0, a1, 32'h340, waw, 32'h344));
        vecs.push_back(mk(0,0,0,0,1, a1, 32'h350, a2, 32'h354,   0,1,0,0, 0, 0, a2, 32'h354));
        vecs.push_back(mk(0,0,0,1,0, a1, 32'h360, a2, 32'h364,   1,0,0,0, a1, 32'h360, 0, 0));
        // split then flush while SECOND
        vecs.push_back(mk(0,0,0,1,1, a1, 32'h400, a2, 32'h404,   1,0,0,0, a1, 32'h400, 0, 0));
        vecs.push_back(mk(0,0,1,1,1, n1, 32'h408, n2, 32'h40c,   0,0,0,1, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, n1, 32'h500, n2, 32'h504,   1,1,0,0, n1, 32'h500, n2, 32'h504));
        // split then 3 stalled cycles in SECOND
        vecs.push_back(mk(0,0,0,1,1, a1, 32'h600, a2, 32'h604,   1,0,0,0, a1, 32'h600, 0, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0,1,0,1,1, n1, 32'h608, n2, 32'h60c, 1,0,1,1, a2, 32'h604, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, n1, 32'h608, n2, 32'h60c,   1,0,1,1, a2, 32'h604, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, n1, 32'h608, n2, 32'h60c,   1,1,0,0, n1, 32'h608, n2, 32'h60c));
        // stall on a conflicting pair holds PAIR without capture
        vecs.push_back(mk(0,1,0,1,1, a1, 32'h700, a2, 32'h704,   1,0,1,0, a1, 32'h700, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, a1, 32'h700, a2, 32'h704,   1,0,0,0, a1, 32'h700, 0, 0));
        // reset while SECOND
        vecs.push_back(mk(1,0,0,1,1, n1, 32'h708, n2, 32'h70c,   0,0,0,0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, n1, 32'h800, n2, 32'h804,   1,1,0,0, n1, 32'h800, n2, 32'h804));
        // flush beats stall and conflict in PAIR
        vecs.push_back(mk(0,1,1,1,1, a1, 32'h900, a2, 32'h904,   0,0,0,0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, a1, 32'h900, a2, 32'h904,   1,0,0,0, a1, 32'h900, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, n1, 32'h908, n2, 32'h90c,   1,0,1,1, a2, 32'h904, 0, 0));
        vecs.push_back(mk(0,0,0,1,1, n1, 32'h908, n2, 32'h90c,   1,1,0,0, n1, 32'h908, n2, 32'h90c));

        rst = 1'b1; StallIn = 1'b0; FlushD = 1'b0; ValidD1 = 1'b0; ValidD2 = 1'b0;
        InstrD1 = '0; InstrD2 = '0; PCD1 = '0; PCD2 = '0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            v = vecs[i];
            rst = v.rst; StallIn = v.stall; FlushD = v.flush;
            ValidD1 = v.v1; ValidD2 = v.v2;
            InstrD1 = v.i1; PCD1 = v.p1; InstrD2 = v.i2; PCD2 = v.p2;
            sb.push_back(v);
            @(negedge clk);
            e = sb.pop_front();
            chk("ValidL1", i, 32'(ValidL1), 32'(e.ev1));
            chk("ValidL2", i, 32'(ValidL2), 32'(e.ev2));
            chk("StallFD", i, 32'(StallFD), 32'(e.estf));
            chk("SplitBusy", i, 32'(SplitBusy), 32'(e.ebusy));
            if (e.ev1 || e.rst) begin
                chk("InstrL1", i, InstrL1, e.ei1);
                chk("PCL1", i, PCL1, e.ep1);
            end
            if (e.ev2 || e.rst) begin
                chk("InstrL2", i, InstrL2, e.ei2);
                chk("PCL2", i, PCL2, e.ep2);
            end
            if (e.chk_nomem) begin
                chk("nomem_ValidL1", i, 32'(n_ValidL1), 32'd1);
                chk("nomem_ValidL2", i, 32'(n_ValidL2), 32'd1);
                chk("nomem_StallFD", i, 32'(n_StallFD), 32'd0);
                chk("nomem_PCL2", i, n_PCL2, e.p2);
            end
        end
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
        end
        checks++;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
